// File: rtl/bst_pkg.sv
// Shared definitions for the bit-serial adder-tree controller.
// Holds the default geometry, the controller state type and a small
// helper that sizes counters (minimum width of one bit).
package bst_pkg;

   localparam int unsigned N_IN_DEF      = 8;
   localparam int unsigned IN_W_DEF      = 8;
   localparam int unsigned FRAME_LEN_DEF = 32;
   localparam int unsigned TREE_LAT_DEF  = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bst_out_fifo.sv
// Two-entry result buffer between the collector and the consumer.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   push, din     write one word (never issued when full)
//   pop           retire the head word (only issued when not empty)
//   dout          head word; zero after reset
//   count         number of stored words, 0..2
// A push and a pop in the same cycle keep count and preserve order.
module bst_out_fifo
   import bst_pkg::*;
#(
   parameter int unsigned W = FRAME_LEN_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/bit_serial_tree_ctrl.sv
// Controller that feeds an external bit-serial adder tree and gathers its sum.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid/in_ready      operand vector handshake
//   in_data                lane k operand at [k*IN_W +: IN_W], two's complement
//   tree_inputs            one serial bit per lane, LSB first, sign-extended
//   tree_clean             clears the tree carry (IDLE and last bit of a frame)
//   tree_result            serial sum bit, TREE_LAT cycles behind tree_inputs
//   out_valid/out_ready    result handshake from a 2-entry buffer
//   out_data               FRAME_LEN-bit sum of all lanes
//   busy                   streaming, collecting or holding a result
module bit_serial_tree_ctrl
   import bst_pkg::*;
#(
   parameter int unsigned N_IN      = N_IN_DEF,
   parameter int unsigned IN_W      = IN_W_DEF,
   parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
   parameter int unsigned TREE_LAT  = TREE_LAT_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_IN*IN_W-1:0]   in_data,
   output logic [N_IN-1:0]        tree_inputs,
   output logic                   tree_clean,
   input  logic                   tree_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FRAME_LEN-1:0]   out_data,
   output logic                   busy
);

   localparam int unsigned CNT_W = cnt_width(FRAME_LEN);
   localparam int unsigned IDX_W = cnt_width(IN_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

   state_t                 state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [N_IN*IN_W-1:0]   frame_reg;
   logic                   ready_en;
   logic [1:0]             in_flight;
   logic [TREE_LAT-1:0]    sof_pipe;
   logic                   collecting;
   logic [CNT_W-1:0]       col_cnt;
   logic [FRAME_LEN-1:0]   shreg;
   logic [1:0]             fifo_count;
   logic [IDX_W-1:0]       lane_bit;
   logic [CNT_W-1:0]       col_idx;
   logic [FRAME_LEN-1:0]   word;
   logic                   last_bit;
   logic                   in_xfer;
   logic                   out_xfer;
   logic                   sample;
   logic                   push;

   assign last_bit = (bit_cnt == LAST_BIT);

   // Credit check: at most two frames between acceptance and consumption.
   assign in_ready = ready_en
                   && (({1'b0, in_flight} + {1'b0, fifo_count}) < 3'd2)
                   && ((state == IDLE) || last_bit);
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   // Holds in_ready low during reset; rises on the first clock afterwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ready_en <= 1'b0;
      else          ready_en <= 1'b1;
   end

   // Frame sequencer: a new frame may start right after the last bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         frame_reg <= '0;
      end else begin
         if (in_xfer) begin
            frame_reg <= in_data;
         end
         case (state)
            IDLE: begin
               if (in_xfer) begin
                  state   <= STREAM;
                  bit_cnt <= '0;
               end
            end
            STREAM: begin
               if (last_bit) begin
                  bit_cnt <= '0;
                  state   <= in_xfer ? STREAM : IDLE;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               bit_cnt <= '0;
            end
         endcase
      end
   end

   // Past the operand MSB the sign bit is repeated.
   always_comb begin
      lane_bit = IDX_W'(IN_W - 1);
      if (32'(bit_cnt) < IN_W) begin
         lane_bit = IDX_W'(bit_cnt);
      end
   end

   for (genvar k = 0; k < int'(N_IN); k++) begin : g_lane
      logic [IN_W-1:0] operand;
      assign operand        = frame_reg[k*IN_W +: IN_W];
      assign tree_inputs[k] = (state == STREAM) && operand[lane_bit];
   end

   assign tree_clean = (state == IDLE) || last_bit;

   // Collection is aligned by delaying the start-of-frame strobe.
   assign sample  = sof_pipe[TREE_LAT-1] || collecting;
   assign col_idx = sof_pipe[TREE_LAT-1] ? '0 : col_cnt;
   assign word    = {tree_result, shreg[FRAME_LEN-1:1]};
   assign push    = sample && (col_idx == LAST_BIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sof_pipe   <= '0;
         collecting <= 1'b0;
         col_cnt    <= '0;
         shreg      <= '0;
      end else begin
         sof_pipe[0] <= (state == STREAM) && (bit_cnt == '0);
         for (int i = 1; i < int'(TREE_LAT); i++) begin
            sof_pipe[i] <= sof_pipe[i-1];
         end
         if (sample) begin
            shreg <= word;
            if (push) begin
               collecting <= 1'b0;
               col_cnt    <= '0;
            end else begin
               collecting <= 1'b1;
               col_cnt    <= col_idx + CNT_W'(1);
            end
         end
      end
   end

   // Frames accepted whose result has not yet reached the buffer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_flight <= 2'd0;
      end else begin
         case ({in_xfer, push})
            2'b10:   in_flight <= in_flight + 2'd1;
            2'b01:   in_flight <= in_flight - 2'd1;
            default: in_flight <= in_flight;
         endcase
      end
   end

   bst_out_fifo #(
      .W (FRAME_LEN)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (out_xfer),
      .din     (word),
      .dout    (out_data),
      .count   (fifo_count)
   );

   assign out_valid = (fifo_count != 2'd0);
   assign busy      = (state != IDLE) || (in_flight != 2'd0) || (fifo_count != 2'd0);

endmodule

// File: tb/tb_bit_serial_tree_ctrl.sv
// Directed bench: controller plus a behavioural bit-serial adder tree.
module tb_bit_serial_tree_ctrl;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [7:0]  tree_inputs;
   logic        tree_clean;
   logic        tree_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   bit_serial_tree_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .tree_inputs (tree_inputs),
      .tree_clean  (tree_clean),
      .tree_result (tree_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Adder tree: serial multi-operand add, result delayed by two cycles.
   logic [3:0] carry;
   logic [1:0] res_pipe;
   logic [4:0] bit_sum;
   always_comb bit_sum = 5'(carry) + 5'($countones(tree_inputs));
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         carry    <= 4'd0;
         res_pipe <= 2'd0;
      end else begin
         carry    <= tree_clean ? 4'd0 : bit_sum[4:1];
         res_pipe <= {res_pipe[0], bit_sum[0]};
      end
   end
   assign tree_result = res_pipe[1];

   int          checks;
   int          failures;
   int          cyc;
   int          last_pop;
   bit          check_lat;
   bit          check_space;
   logic        rdy;
   logic [63:0] send_q[$];
   logic [31:0] exp_q[$];
   int          xfer_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive ready, check any pop, offer the next queued vector.
   task automatic step();
      int x;
      @(negedge clk);
      cyc++;
      out_ready = rdy;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_pop", 64'(exp_q.size()), 64'd1);
         end else begin
            check("result", 64'(out_data), 64'(exp_q.pop_front()));
            x = (xfer_q.size() != 0) ? xfer_q.pop_front() : 0;
            if (check_lat) check("latency", 64'(cyc - x), 64'd35);
            if (check_space && last_pop >= 0) check("spacing", 64'(cyc - last_pop), 64'd32);
            last_pop = cyc;
         end
      end
      if (send_q.size() != 0) begin
         in_valid = 1'b1;
         in_data  = send_q[0];
         if (in_ready) begin
            void'(send_q.pop_front());
            xfer_q.push_back(cyc);
         end
      end else begin
         in_valid = 1'b0;
         in_data  = {$urandom, $urandom};
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((send_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check("drain", 64'(send_q.size() + exp_q.size()), 64'd0);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
      check(tag, 64'(out_valid), 64'd1);
   endtask

   initial begin
      int w;
      checks      = 0;
      failures    = 0;
      cyc         = 0;
      last_pop    = -1;
      check_lat   = 1'b1;
      check_space = 1'b0;
      rdy         = 1'b1;
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b1;

      // Reset values
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_tree_inputs", 64'(tree_inputs), 64'd0);
      check("rst_tree_clean", 64'(tree_clean), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      step();
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      check("post_rst_busy", 64'(busy), 64'd0);

      // Single frame of -10s, with bit-level look at the first two bits
      send_q.push_back({8{8'hF6}});
      exp_q.push_back(32'hFFFF_FFB0);
      step();
      step();
      check("bit0_inputs", 64'(tree_inputs), 64'h00);
      check("bit0_clean", 64'(tree_clean), 64'd0);
      check("bit0_busy", 64'(busy), 64'd1);
      step();
      check("bit1_inputs", 64'(tree_inputs), 64'hFF);
      drain(100);
      step();
      check("idle_busy", 64'(busy), 64'd0);

      // Extremes, back to back
      send_q.push_back({8{8'h7F}});
      exp_q.push_back(32'd1016);
      send_q.push_back({8{8'h80}});
      exp_q.push_back(32'hFFFF_FC00);
      drain(200);

      // Sweep: lanes {a,b,a,b,b,b,b,a}, lane 0 in the low byte
      for (int a = -10; a <= 9; a++) begin
         for (int b = -10; b <= 9; b++) begin
            send_q.push_back({8'(a), 8'(b), 8'(b), 8'(b), 8'(b), 8'(a), 8'(b), 8'(a)});
            exp_q.push_back(32'(3*a + 5*b));
         end
      end
      check_space = 1'b1;
      last_pop    = -1;
      drain(400*32 + 200);
      check_space = 1'b0;
      step();

      // Backpressure: only two frames may be outstanding
      check_lat = 1'b0;
      rdy       = 1'b0;
      send_q.push_back({8{8'h05}});
      exp_q.push_back(32'd40);
      send_q.push_back({8{8'hFD}});
      exp_q.push_back(32'hFFFF_FFE8);
      send_q.push_back({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
      exp_q.push_back(32'd36);
      repeat (120) step();
      check("bp_accepted", 64'(3 - send_q.size()), 64'd2);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      rdy = 1'b1;
      drain(200);
      step();

      // Push and pop in the same cycle with one word buffered
      rdy = 1'b0;
      send_q.push_back({8{8'h02}});
      exp_q.push_back(32'd16);
      send_q.push_back({8{8'hFF}});
      exp_q.push_back(32'hFFFF_FFF8);
      wait_valid("pp_first_valid");
      repeat (30) step();
      check("pp_count_before", 64'(dut.u_fifo.count), 64'd1);
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      step();
      check("pp_count_after", 64'(dut.u_fifo.count), 64'd1);
      check("pp_valid_after", 64'(out_valid), 64'd1);
      check("pp_head_after", 64'(out_data), 64'hFFFF_FFF8);
      rdy = 1'b1;
      drain(100);
      step();

      // Reset in the middle of a frame with a result already buffered
      rdy = 1'b0;
      send_q.push_back({8{8'h01}});
      exp_q.push_back(32'd8);
      wait_valid("mr_buffered_valid");
      send_q.push_back({8{8'h33}});
      exp_q.push_back(32'd408);
      w = 0;
      while (xfer_q.size() < 2 && w < 100) begin
         step();
         w++;
      end
      repeat (16) step();
      check("mr_bit_cnt", 64'(dut.bit_cnt), 64'd15);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mr_in_ready", 64'(in_ready), 64'd0);
      check("mr_out_valid", 64'(out_valid), 64'd0);
      check("mr_out_data", 64'(out_data), 64'd0);
      check("mr_tree_inputs", 64'(tree_inputs), 64'd0);
      check("mr_tree_clean", 64'(tree_clean), 64'd1);
      check("mr_busy", 64'(busy), 64'd0);
      send_q.delete();
      exp_q.delete();
      xfer_q.delete();
      last_pop = -1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rdy     = 1'b1;
      repeat (80) step();
      check("mr_no_stale", 64'(out_valid), 64'd0);
      check("mr_idle_busy", 64'(busy), 64'd0);
      check_lat = 1'b1;
      send_q.push_back({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
      exp_q.push_back(32'd36);
      drain(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bit_serial_tree_ctrl.md
BIT_SERIAL_TREE_CTRL -- requirements
Module: bit_serial_tree_ctrl

Interface
REQ-001 Parameter N_IN, default 8: number of adder_tree operand lanes.
REQ-002 Parameter IN_W, default 8: operand width, two's complement.
REQ-003 Parameter FRAME_LEN, default 32: bits per serial frame and result width.
REQ-004 Parameter TREE_LAT, default 2: cycles from a bit on tree_inputs to the matching bit on tree_result.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand vector offered.
- in_ready  out  1  controller accepts the vector this cycle.
- in_data  in  N_IN*IN_W  lane k operand at bits [k*IN_W +: IN_W].
- tree_inputs  out  N_IN  one serial bit per lane to adder_tree.inputs.
- tree_clean  out  1  drives adder_tree.clean.
- tree_result  in  1  adder_tree.result serial bit.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  FRAME_LEN  sum of the N_IN operands.
- busy  out  1  any frame streaming, collecting, or buffered.

Function
REQ-006 A transfer occurs when in_valid && in_ready; the rule is identical on the output side.
REQ-007 States: IDLE and STREAM. IDLE->STREAM on an input transfer. In STREAM, bit_cnt counts 0..FRAME_LEN-1.
REQ-008 At bit_cnt = FRAME_LEN-1, STREAM->STREAM (bit_cnt=0) on a new transfer; otherwise STREAM->IDLE.
REQ-009 Start of a frame: the cycle after its transfer, with bit_cnt=0. Back-to-back frames have no gap cycles.
REQ-010 During STREAM: tree_inputs[k] = operand_k[bit_cnt] for bit_cnt < IN_W, else operand_k[IN_W-1] (sign extension).
REQ-011 tree_inputs = 0 in IDLE.
REQ-012 tree_clean = 1 in IDLE and when bit_cnt = FRAME_LEN-1; otherwise 0.
REQ-013 Operands are latched on transfer into a frame register; in_data is don't-care afterwards.
REQ-014 Collection: frame bit i is sampled from tree_result exactly TREE_LAT cycles after that bit is on tree_inputs, LSB first, into a FRAME_LEN shift register.
REQ-015 The start-of-frame strobe is delayed by a TREE_LAT-deep pipe to align collection.
REQ-016 After bit FRAME_LEN-1 is sampled, the word is pushed into a 2-entry output FIFO.
REQ-017 out_valid = FIFO not empty; out_data = FIFO head.
REQ-018 out_data is the two's-complement sum of the N_IN operands, modulo 2^FRAME_LEN.
REQ-019 Credit rule: in_ready = (frames_in_flight + fifo_count < 2) && (IDLE || bit_cnt = FRAME_LEN-1).
REQ-020 frames_in_flight counts transfers whose result is not yet pushed. A push and an input transfer in the same cycle leave it unchanged.
REQ-021 A pop and a push in the same cycle leave fifo_count unchanged and preserve order. FIFO overflow is unreachable by REQ-019.
REQ-022 busy = (state != IDLE) || frames_in_flight != 0 || fifo_count != 0.
REQ-023 Steady-state throughput with out_ready=1: one result per FRAME_LEN cycles.
REQ-024 Latency from transfer to out_valid: FRAME_LEN + TREE_LAT + 1 cycles.

Reset
REQ-025 reset_n low asynchronously sets: state=IDLE, bit_cnt=0, frames_in_flight=0, FIFO empty, delay pipe cleared, shift register cleared.
REQ-026 Outputs during reset: in_ready=0, out_valid=0, out_data=0, tree_inputs=0, tree_clean=1, busy=0.
REQ-027 Reset mid-frame discards all partial and buffered results; no stale result is emitted.
REQ-028 in_ready may rise in the first cycle after reset_n deasserts.

Structure
REQ-029 Shared package bst_pkg holds the N_IN/IN_W/FRAME_LEN defaults and the state enum {IDLE, STREAM}.
REQ-030 The 2-entry output buffer is a sub-module, bst_out_fifo (clk, reset_n, push, pop, din, dout, count).
REQ-031 The controller instantiates neither adder_tree nor the FIFO's consumer; adder_tree is connected at top level.

Verification
REQ-032 Bench connects the controller to adder_tree and checks every popped result against a scoreboard.
- Single frame, lanes {-10,-10,-10,-10,-10,-10,-10,-10} -> out_data = -80 (0xFFFFFFB0), out_valid at transfer+FRAME_LEN+TREE_LAT+1.
- Extremes: all lanes 127 -> 1016; all lanes -128 -> -1024 (0xFFFFFC00).
- Back-to-back sweep, a,b in [-10,9], lanes {a,b,a,b,b,b,b,a}, out_ready=1 -> 400 results equal to 3a+5b in order, frames spaced exactly 32 cycles.
- out_ready=0 with in_valid=1 -> exactly 2 frames accepted, then in_ready=0. Raising out_ready -> both results in order, then acceptance resumes.
- reset_n pulsed low at bit_cnt=15 of a frame -> outputs take REQ-026 values immediately, no result from that frame; the next frame {1,2,3,4,5,6,7,8} yields 36.
- Simultaneous push and pop with fifo_count=1 -> count stays 1, order preserved.
